pll_lock_ctrl: RTL and testbench

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl_pkg.sv | 21 ++
 rtl/pll_lock_ctrl_sync_2ff.sv | 12 +
 rtl/pll_lock_ctrl.sv | 90 +++++++++
 tb/tb_pll_lock_ctrl.sv | 110 +++++++++++
 4 files changed

// File: rtl/pll_lock_ctrl_pkg.sv
// pll_lock_ctrl_pkg: FSM state encoding, default timing constants and output decode shared by the PLL lock controller
package pll_lock_ctrl_pkg;
  typedef enum logic [2:0] {
    S_RST    = 3'd0,
    S_WAIT   = 3'd1,
    S_STABLE = 3'd2,
    S_RUN    = 3'd3,
    S_FAIL   = 3'd4
  } state_t;
  localparam int DEF_RST_PULSE_CYC    = 16;
  localparam int DEF_LOCK_STABLE_CYC  = 1024;
  localparam int DEF_LOCK_TIMEOUT_CYC = 65536;
  localparam int DEF_MAX_RETRY        = 4;
  function automatic int max3(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  // {pll_reset, rstn_out, locked, fail} for a given state
  function automatic logic [3:0] outs(input state_t s);
    return {s == S_RST || s == S_FAIL, s == S_RUN, s == S_RUN, s == S_FAIL};
  endfunction
endpackage

// File: rtl/pll_lock_ctrl_sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous bit, cleared to 0 by reset
module sync_2ff (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);
  logic meta;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset pulse, lock qualification, timeout/retry and release of the PLL-clocked reset.
// Optional PLL_LOCK_LOSS_CNT_EN adds loss_cnt_o, counting lock losses while running.
module pll_lock_ctrl
  import pll_lock_ctrl_pkg::*;
#(
  parameter int RST_PULSE_CYC    = DEF_RST_PULSE_CYC,
  parameter int LOCK_STABLE_CYC  = DEF_LOCK_STABLE_CYC,
  parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
  parameter int MAX_RETRY        = DEF_MAX_RETRY
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       lock_i,
  input  logic       relock_req_i,
  output logic       pll_reset_o,
  output logic       rstn_out,
  output logic       locked_o,
  output logic       fail_o,
`ifdef PLL_LOCK_LOSS_CNT_EN
  output logic [3:0] retry_cnt_o,
  output logic [7:0] loss_cnt_o
`else
  output logic [3:0] retry_cnt_o
`endif
);
  localparam int CW = $clog2(max3(RST_PULSE_CYC, LOCK_STABLE_CYC, LOCK_TIMEOUT_CYC)) + 1;
  state_t state, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] retry_n, retry_inc;
  logic lock_s;
  sync_2ff u_sync (.clk(clk), .resetn(resetn), .d(lock_i), .q(lock_s));
  assign retry_inc = retry_cnt_o == 4'hf ? 4'hf : retry_cnt_o + 4'd1;
  // relock has priority over every state-specific transition
  always_comb begin
    nxt     = state;
    cnt_n   = cnt + 1'b1;
    retry_n = retry_cnt_o;
    if (relock_req_i) begin
      nxt     = S_RST;
      cnt_n   = '0;
      retry_n = '0;
    end else begin
      case (state)
        S_RST: if (cnt == CW'(RST_PULSE_CYC - 1)) begin
          nxt   = S_WAIT;
          cnt_n = '0;
        end
        S_WAIT: if (lock_s) begin
          nxt   = S_STABLE;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_TIMEOUT_CYC - 1)) begin
          retry_n = retry_inc;
          nxt     = retry_inc < 4'(MAX_RETRY) ? S_RST : S_FAIL;
          cnt_n   = '0;
        end
        S_STABLE: if (!lock_s) begin
          nxt   = S_WAIT;
          cnt_n = '0;
        end else if (cnt == CW'(LOCK_STABLE_CYC - 1)) begin
          nxt     = S_RUN;
          cnt_n   = '0;
          retry_n = '0;
        end
        S_RUN: begin
          cnt_n = '0;
          nxt   = lock_s ? S_RUN : S_RST;
        end
        default: cnt_n = '0;
      endcase
    end
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state       <= S_RST;
      cnt         <= '0;
      retry_cnt_o <= '0;
      {pll_reset_o, rstn_out, locked_o, fail_o} <= 4'b1000;
    end else begin
      state       <= nxt;
      cnt         <= cnt_n;
      retry_cnt_o <= retry_n;
      {pll_reset_o, rstn_out, locked_o, fail_o} <= outs(nxt);
    end
`ifdef PLL_LOCK_LOSS_CNT_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) loss_cnt_o <= '0;
    else if (state == S_RUN && !lock_s && !relock_req_i && loss_cnt_o != 8'hff)
      loss_cnt_o <= loss_cnt_o + 8'd1;
`endif
endmodule

// File: tb/tb_pll_lock_ctrl.sv
// tb_pll_lock_ctrl: run-length vector table with a per-cycle scoreboard, plus async reset corner cases
module tb_pll_lock_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic lock = 1'b0;
  logic relock = 1'b0;
  logic pll_reset, rstn_out, locked, fail;
  logic [3:0] retry;
  logic [7:0] obs;
  typedef struct {
    int         n;
    logic       lock;
    logic       relock;
    logic [7:0] exp;
    string      name;
  } row_t;
  row_t tbl[$];
  logic [7:0] sb[$];
  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
`ifdef PLL_LOCK_LOSS_CNT_EN
  logic [7:0] loss;
`endif
  pll_lock_ctrl #(
    .RST_PULSE_CYC(4), .LOCK_STABLE_CYC(8), .LOCK_TIMEOUT_CYC(32), .MAX_RETRY(2)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .lock_i(lock),
    .relock_req_i(relock),
    .pll_reset_o(pll_reset),
    .rstn_out(rstn_out),
    .locked_o(locked),
    .fail_o(fail),
`ifdef PLL_LOCK_LOSS_CNT_EN
    .retry_cnt_o(retry),
    .loss_cnt_o(loss)
`else
    .retry_cnt_o(retry)
`endif
  );
  always #5 clk = ~clk;
  assign obs = {pll_reset, rstn_out, locked, fail, retry};
  function automatic logic [7:0] e(input logic pr, input logic rn, input logic lk, input logic f, input logic [3:0] r);
    return {pr, rn, lk, f, r};
  endfunction
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc %0d: got {pr,rn,lk,f,retry}=%h want %h", name, cyc, act, exp);
  endtask
  task automatic step(input logic l, input logic r, input logic [7:0] x, input string name);
    lock = l;
    relock = r;
    sb.push_back(x);
    @(negedge clk);
    cyc++;
    chk(name, obs, sb.pop_front());
  endtask
  task automatic add(input int n, input logic l, input logic r, input logic [7:0] x, input string name);
    tbl.push_back('{n: n, lock: l, relock: r, exp: x, name: name});
  endtask
  initial begin
    add(3,  0, 0, e(1,0,0,0,0), "rst_pulse");
    add(7,  0, 0, e(0,0,0,0,0), "wait");
    add(10, 1, 0, e(0,0,0,0,0), "qualify");
    add(4,  1, 0, e(0,1,1,0,0), "run");
    add(2,  0, 0, e(0,1,1,0,0), "loss_sync");
    add(4,  0, 0, e(1,0,0,0,0), "loss_rst");
    add(32, 0, 0, e(0,0,0,0,0), "timeout1");
    add(4,  0, 0, e(1,0,0,0,1), "retry1_rst");
    add(32, 0, 0, e(0,0,0,0,1), "timeout2");
    add(10, 0, 0, e(1,0,0,1,2), "fail");
    add(1,  0, 1, e(1,0,0,0,0), "relock_fail");
    add(3,  0, 0, e(1,0,0,0,0), "relock_rst");
    add(1,  0, 0, e(0,0,0,0,0), "relock_wait");
    add(6,  1, 0, e(0,0,0,0,0), "pre_glitch");
    add(1,  0, 0, e(0,0,0,0,0), "glitch");
    add(10, 1, 0, e(0,0,0,0,0), "requalify");
    add(3,  1, 0, e(0,1,1,0,0), "run2");
    add(2,  0, 0, e(0,1,1,0,0), "loss2_sync");
    add(1,  0, 1, e(1,0,0,0,0), "relock_and_loss");
    add(3,  0, 0, e(1,0,0,0,0), "single_rst");
    add(1,  0, 0, e(0,0,0,0,0), "after_rst");
    repeat (2) @(negedge clk);
    chk("in_reset", obs, e(1,0,0,0,0));
    resetn = 1'b1;
    #1 chk("release", obs, e(1,0,0,0,0));
    foreach (tbl[k])
      for (int i = 0; i < tbl[k].n; i++) step(tbl[k].lock, tbl[k].relock, tbl[k].exp, tbl[k].name);
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("loss_cnt", loss, 8'd1);
`endif
    for (int i = 0; i < 5; i++) step(1, 0, e(0,0,0,0,0), "to_stable");
    #2 resetn = 1'b0;
    #1 chk("async_rst", obs, e(1,0,0,0,0));
    @(negedge clk);
    chk("rst_hold", obs, e(1,0,0,0,0));
`ifdef PLL_LOCK_LOSS_CNT_EN
    chk("loss_clr", loss, 8'd0);
`endif
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) step(1, 0, e(1,0,0,0,0), "rerelease_rst");
    for (int i = 0; i < 9; i++) step(1, 0, e(0,0,0,0,0), "rerelease_qual");
    step(1, 0, e(0,1,1,0,0), "rerelease_run");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
